// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: captures retirement records into a FIFO and
// serialises each record as four 32-bit words on a valid/ready stream.
// Overflowed records are counted and later reported by a drop-marker record.
module ibex_rvfi_trace_buffer #(
   parameter int unsigned Depth        = 8,
   parameter int unsigned DropCntWidth = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       enable_i,
   input  logic                       rvfi_valid,
   input  logic [63:0]                rvfi_order,
   input  logic [31:0]                rvfi_insn,
   input  logic                       rvfi_trap,
   input  logic                       rvfi_halt,
   input  logic                       rvfi_intr,
   input  logic [1:0]                 rvfi_mode,
   input  logic [4:0]                 rvfi_rd_addr,
   input  logic [31:0]                rvfi_rd_wdata,
   input  logic [31:0]                rvfi_pc_rdata,
   output logic                       trace_valid_o,
   input  logic                       trace_ready_i,
   output logic [31:0]                trace_data_o,
   output logic                       trace_last_o,
   output logic [$clog2(Depth):0]     level_o,
   output logic [DropCntWidth-1:0]    drop_cnt_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned LvlW = PtrW + 1;
   localparam logic [31:0] MarkerTag = 32'hDEAD_D0D0;

   typedef enum logic [1:0] {
      W0 = 2'd0,
      W1 = 2'd1,
      W2 = 2'd2,
      W3 = 2'd3
   } word_e;

   word_e                   state;
   word_e                   state_next;

   logic [127:0]            mem [Depth];
   logic [PtrW-1:0]         wr_ptr;
   logic [PtrW-1:0]         rd_ptr;
   logic [LvlW-1:0]         level;
   logic                    pending_drop;
   logic [DropCntWidth-1:0] cur_drop;
   logic [DropCntWidth-1:0] drop_cnt;

   logic                    capture;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    push_marker;
   logic                    pop;
   logic [127:0]            push_rec;
   logic [127:0]            head_rec;
   logic [31:0]             norm_w2;
   logic [31:0]             norm_w3;

   // Upper order bits are not part of the record.
   logic                    unused_order;
   assign unused_order = ^rvfi_order[63:16];

   function automatic logic [DropCntWidth-1:0] sat_inc(input logic [DropCntWidth-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Capture decision and record assembly; a pending marker takes priority
   // over an incoming record so the gap is reported in stream order.
   always_comb begin
      capture     = rvfi_valid & enable_i;
      full        = (level == LvlW'(Depth));
      empty       = (level == '0);
      push_marker = pending_drop & ~full;
      push        = push_marker | (capture & ~full & ~pending_drop);
      norm_w2     = (rvfi_rd_addr == 5'd0) ? 32'h0 : rvfi_rd_wdata;
      norm_w3     = {rvfi_order[15:0], rvfi_mode, rvfi_rd_addr,
                     rvfi_trap, rvfi_intr, rvfi_halt, 6'b0};
      if (push_marker) begin
         push_rec = {32'h0000_0001, 32'h0, 32'(cur_drop), MarkerTag};
      end else begin
         push_rec = {norm_w3, norm_w2, rvfi_insn, rvfi_pc_rdata};
      end
   end

   // FIFO storage; contents need no reset since level gates visibility.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= push_rec;
      end
   end

   // FIFO pointers, occupancy and drop accounting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         pending_drop <= 1'b0;
         cur_drop     <= '0;
         drop_cnt     <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (!push && pop) begin
            level <= level - 1'b1;
         end
         if (push_marker) begin
            // A retire in the marker cycle is dropped and starts a new gap.
            pending_drop <= capture;
            cur_drop     <= {{(DropCntWidth-1){1'b0}}, capture};
            if (capture) begin
               drop_cnt <= sat_inc(drop_cnt);
            end
         end else if (capture && (full || pending_drop)) begin
            pending_drop <= 1'b1;
            cur_drop     <= sat_inc(cur_drop);
            drop_cnt     <= sat_inc(drop_cnt);
         end
      end
   end

   // Serialiser word-index register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= W0;
      end else begin
         state <= state_next;
      end
   end

   // Serialiser next-state and stream outputs from the FIFO head.
   always_comb begin
      state_next    = state;
      trace_valid_o = ~empty;
      trace_data_o  = '0;
      trace_last_o  = 1'b0;
      pop           = 1'b0;
      head_rec      = mem[rd_ptr];
      if (!empty) begin
         case (state)
            W0:      trace_data_o = head_rec[31:0];
            W1:      trace_data_o = head_rec[63:32];
            W2:      trace_data_o = head_rec[95:64];
            default: trace_data_o = head_rec[127:96];
         endcase
         trace_last_o = (state == W3);
         if (trace_ready_i) begin
            case (state)
               W0:      state_next = W1;
               W1:      state_next = W2;
               W2:      state_next = W3;
               default: state_next = W0;
            endcase
            pop = (state == W3);
         end
      end
   end

   assign level_o    = level;
   assign drop_cnt_o = drop_cnt;

endmodule

// File: doc/ibex_rvfi_trace_buffer.md
Name: ibex_rvfi_trace_buffer

Overview:
- Downstream consumer of the core's RVFI retirement port; sits beside the simulation tracer in the tracing top level.
- Captures one retirement record per `rvfi_valid` pulse into a record FIFO.
- Serialises each record as four 32-bit words onto a valid/ready trace stream for an off-core trace sink.
- On overflow, drops records, counts them, and later inserts a drop-marker record so the sink can detect the gap.

Parameters:
- Depth, 8, FIFO capacity in records; power of two, ≥2.
- DropCntWidth, 16, width of drop counters; counters saturate, never wrap.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- enable_i  in  1  capture enable; low = no capture, no drop counting
- rvfi_valid  in  1  retirement strobe
- rvfi_order  in  64  retirement order; only [15:0] is used
- rvfi_insn  in  32  retired instruction
- rvfi_trap  in  1  trap flag
- rvfi_halt  in  1  halt flag
- rvfi_intr  in  1  first instruction of trap handler
- rvfi_mode  in  2  privilege mode
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- rvfi_pc_rdata  in  32  PC of retired instruction
- trace_valid_o  out  1  stream word valid
- trace_ready_i  in  1  sink ready
- trace_data_o  out  32  stream word
- trace_last_o  out  1  high on word 3 of each record
- level_o  out  $clog2(Depth)+1  records currently held
- drop_cnt_o  out  DropCntWidth  cumulative dropped records, saturating

Behaviour:
- Reset (`rst_i` sampled high at clk edge): FIFO empty, word index 0, `pending_drop`=0, `cur_drop`=0. Outputs `trace_valid_o`=0, `trace_data_o`=0, `trace_last_o`=0, `level_o`=0, `drop_cnt_o`=0. Reset mid-record discards the partial record; there is no resumption.
- Normal record layout:
  - word0 = `rvfi_pc_rdata`
  - word1 = `rvfi_insn`
  - word2 = `rvfi_rd_wdata`, forced to 0 when `rvfi_rd_addr`==0
  - word3 = {order[15:0], mode[1:0], rd_addr[4:0], trap, intr, halt, 5'b0, 1'b0}; bit0 = 0 marks a normal record
- Marker record layout:
  - word0 = 32'hDEAD_D0D0
  - word1 = `cur_drop` zero-extended to 32 bits
  - word2 = 0
  - word3 = 32'h0000_0001; bit0 = 1 marks a marker
- `full` = (level == Depth), evaluated on the registered level. A pop in the same cycle does not free space for a push in that cycle.
- Capture cycle, with c = `rvfi_valid` & `enable_i`. Exactly one of the following applies:
  - `pending_drop` & !`full`: write the marker; clear `pending_drop`; `cur_drop` ← (c ? 1 : 0); if c, set `pending_drop`=1 again and increment `drop_cnt_o`. The incoming record is dropped so ordering is preserved.
  - c & (`full` | `pending_drop`): drop the record; `pending_drop`←1; `cur_drop`++ (saturating); `drop_cnt_o`++ (saturating).
  - c & !`full` & !`pending_drop`: write the normal record.
- Latency: a record written at edge N makes `trace_valid_o`=1 with word0 from edge N onward, i.e. it is visible in the cycle after the `rvfi_valid` cycle.
- Serialiser FSM over the FIFO head:
  - States W0→W1→W2→W3→W0; advance only on `trace_valid_o` & `trace_ready_i`.
  - `trace_valid_o` = FIFO not empty.
  - `trace_data_o` = head word[state]; 0 when empty.
  - `trace_last_o` = `trace_valid_o` & (state==W3).
  - Accepting W3 pops the head.
  - While `trace_valid_o` & !`trace_ready_i`, data and last are held stable.
- Simultaneous push and pop: level unchanged. Pointers wrap modulo Depth.
- `enable_i` low: no writes, no drop counting; the FIFO continues to drain; `pending_drop` still flushes its marker once space exists.
- `rvfi_order`[63:16] is ignored.

Test Plan:
- Single retire: pc=0x100, insn=0x00A00093, rd=1, wdata=0xA, order=5, mode=3, `trace_ready_i`=1. Expect 4 beats next cycle: 0x100, 0x00A00093, 0xA, 0x0005_C200. `trace_last_o` only on beat 4; `level_o` returns to 0.
- rd=0 with wdata=0x1234 → word2=0.
- Backpressure: `trace_ready_i`=0 for 5 cycles mid-record (state W2). Data stays on word2; resumes on ready; no beat duplicated or lost.
- Overflow, Depth=8, `trace_ready_i`=0: 11 back-to-back retires. Expect `level_o`=8, `drop_cnt_o`=3. Raise ready: 8 normal records, then marker {0xDEADD0D0, 3, 0, 1}.
- Retire arriving in the marker-write cycle: dropped. `drop_cnt_o` increments and a second marker with count 1 follows.
- Reset asserted during word1 of a record: all outputs 0 next cycle; `level_o`=0; no stale words after reset.
- Push and pop in same cycle at level=Depth: the push is dropped and `level_o` becomes Depth-1.
